bp_me_mem_cmd_arbiter: RTL and testbench
========================================

BP_ME_MEM_CMD_ARBITER -- requirements
Module: bp_me_mem_cmd_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of requesters (CCEs or cfg loader) sharing one memory port; legal range 2..4.
REQ-002 SHALL have parameter msg_width_p, default cce_mem_msg_width_lp: width of one memory message.
REQ-003 SHALL have parameter max_outstanding_p, default 4: maximum number of commands issued whose responses have not yet been consumed; legal range 1..8.
REQ-004 Reset (already decided): SHALL use one clock, clk_i; reset_i is asynchronous and active-high.
REQ-005 Ports (name  direction  width  meaning):
- clk_i  in  1  clock
- reset_i  in  1  async active-high reset
- freeze_i  in  1  blocks new grants when high
- cmd_i  in  num_req_p*msg_width_p  requester commands, slot i = requester i
- cmd_v_i  in  num_req_p  per-requester command valid
- cmd_yumi_o  out  num_req_p  per-requester command consumed
- mem_cmd_o  out  msg_width_p  command to memory
- mem_cmd_v_o  out  1  memory command valid
- mem_cmd_ready_i  in  1  memory ready
- mem_resp_i  in  msg_width_p  response from memory
- mem_resp_v_i  in  1  response valid
- mem_resp_yumi_o  out  1  response consumed
- resp_o  out  msg_width_p  response data, broadcast to all requesters
- resp_v_o  out  num_req_p  one-hot response valid
- resp_yumi_i  in  num_req_p  per-requester response consumed
- outstanding_o  out  clog2(max_outstanding_p+1)  current outstanding count
- idle_o  out  1  high when outstanding count is 0
- error_o  out  1  sticky protocol error

Function
REQ-006 Eligible = cmd_v_i & {num_req_p{credit_ok & ~freeze_i}}; credit_ok = outstanding < max_outstanding_p.
REQ-007 Selection SHALL be round-robin: the lowest index at or after rr_ptr, wrapping modulo num_req_p, among eligible requesters.
REQ-008 mem_cmd_v_o SHALL equal OR(eligible); mem_cmd_o SHALL be cmd_i of the selected slot; mem_cmd_v_o SHALL NOT depend on mem_cmd_ready_i.
REQ-009 Command handshake = mem_cmd_v_o & mem_cmd_ready_i; in that cycle only cmd_yumi_o[sel] SHALL be 1; otherwise all cmd_yumi_o SHALL be 0.
REQ-010 On a command handshake, rr_ptr SHALL become (sel+1) mod num_req_p next cycle; otherwise rr_ptr SHALL hold.
REQ-011 Order FIFO: depth max_outstanding_p, entries of clog2(num_req_p) bits; SHALL push sel on a command handshake and pop on a response handshake.
REQ-012 Outstanding counter: +1 on command handshake, -1 on response handshake, unchanged when both occur in the same cycle; it SHALL never exceed max_outstanding_p.
REQ-013 Memory returns responses in command order; head = order FIFO head.
REQ-014 resp_o SHALL equal mem_resp_i; resp_v_o[head] = mem_resp_v_i & (outstanding != 0); all other resp_v_o bits SHALL be 0.
REQ-015 mem_resp_yumi_o = resp_v_o[head] & resp_yumi_i[head]; this is the response handshake; resp_yumi_i bits of non-head requesters SHALL be ignored.
REQ-016 Response with outstanding==0: mem_resp_v_i high while the registered count is 0 SHALL set error_o, and the response SHALL NOT be consumed; this applies even if a command handshake occurs in the same cycle.
REQ-017 error_o SHALL stay set until reset.
REQ-018 idle_o = (outstanding == 0); outstanding_o SHALL reflect the registered count.
REQ-019 freeze_i SHALL block only new grants; in-flight responses SHALL still be routed and drained.
REQ-020 Credit full: when outstanding == max_outstanding_p, mem_cmd_v_o SHALL be 0. A response handshake in that cycle SHALL NOT enable a same-cycle grant; a grant is permitted the following cycle.

Reset
REQ-021 While reset_i is asserted, asynchronously: rr_ptr=0, outstanding=0, order FIFO empty, error_o=0. Hence mem_cmd_v_o=0, cmd_yumi_o=0, resp_v_o=0, mem_resp_yumi_o=0, idle_o=1.
REQ-022 Reset asserted mid-operation SHALL discard all outstanding tracking with no residual grant or response routing.

Verification
REQ-023 Round-robin: num_req_p=2, both cmd_v_i high, mem_cmd_ready_i=1, responses withheld -> grants 0,1,0,1; outstanding reaches 4, then mem_cmd_v_o=0.
REQ-024 Routing: commands issued by requesters 1,0,1, then three in-order responses -> resp_v_o = 2'b10, 2'b01, 2'b10; idle_o=1 after the third yumi.
REQ-025 Simultaneous events: outstanding=2, command and response handshakes in the same cycle -> outstanding stays 2; FIFO head advances and the new id is appended.
REQ-026 Backpressure: resp_yumi_i[head]=0 for 5 cycles -> mem_resp_yumi_o=0 and resp_v_o held stable; a yumi on a non-head requester has no effect.
REQ-027 Error: mem_resp_v_i=1 with outstanding=0 -> error_o=1 next cycle, mem_resp_yumi_o=0; error_o remains 1 until reset_i.
REQ-028 Freeze and reset: freeze_i=1 with 2 outstanding -> no new grants, both responses delivered; reset_i pulsed with 3 outstanding -> outstanding_o=0 immediately and rr_ptr=0.

Source files
------------

// File: rtl/bp_me_mem_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// bp_me_mem_cmd_arbiter
//
// Purpose:
//   Shares one memory command/response port among num_req_p requesters.
//   - Commands are granted round-robin, limited by a credit count of
//     outstanding commands.
//   - An order FIFO records the requester of each issued command.
//   - Memory returns responses in command order. Each response is routed
//     one-hot to the requester at the head of the order FIFO.
//
// Ports:
//   clk_i, reset_i       clock, asynchronous active-high reset
//   freeze_i             blocks new grants (responses still drain)
//   cmd_i / cmd_v_i      per-requester command and valid (slot i = requester i)
//   cmd_yumi_o           per-requester command consumed
//   mem_cmd_o / _v_o     command to memory, valid independent of ready
//   mem_cmd_ready_i      memory accepts a command
//   mem_resp_i / _v_i    response from memory
//   mem_resp_yumi_o      response consumed (head requester took it)
//   resp_o / resp_v_o    broadcast response data, one-hot valid
//   resp_yumi_i          per-requester response consumed (only head counts)
//   outstanding_o        registered outstanding command count
//   idle_o               outstanding count is zero
//   error_o              sticky: response arrived with nothing outstanding
// ----------------------------------------------------------------------------
module bp_me_mem_cmd_arbiter #(
    parameter int num_req_p         = 2,
    // Default memory message width.
    parameter int msg_width_p       = 64,
    parameter int max_outstanding_p = 4,
    localparam int lg_req_lp        = $clog2(num_req_p),
    localparam int cnt_w_lp         = $clog2(max_outstanding_p + 1),
    localparam int ptr_w_lp         = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             freeze_i,
    input  logic [num_req_p*msg_width_p-1:0] cmd_i,
    input  logic [num_req_p-1:0]             cmd_v_i,
    output logic [num_req_p-1:0]             cmd_yumi_o,
    output logic [msg_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]           mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,
    output logic [msg_width_p-1:0]           resp_o,
    output logic [num_req_p-1:0]             resp_v_o,
    input  logic [num_req_p-1:0]             resp_yumi_i,
    output logic [cnt_w_lp-1:0]              outstanding_o,
    output logic                             idle_o,
    output logic                             error_o
);

    logic [lg_req_lp-1:0] r_rr_ptr;
    logic [cnt_w_lp-1:0]  r_outstanding;
    logic [ptr_w_lp-1:0]  r_wr_ptr;
    logic [ptr_w_lp-1:0]  r_rd_ptr;
    logic [lg_req_lp-1:0] r_order_mem [max_outstanding_p];
    logic                 r_error;

    logic                 w_credit_ok;
    logic [num_req_p-1:0] w_eligible;
    logic [lg_req_lp-1:0] w_sel;
    logic                 w_grant_v;
    logic                 w_cmd_hs;
    logic [lg_req_lp-1:0] w_head;
    logic                 w_resp_ok;
    logic                 w_resp_hs;
    int                   w_idx;

    // Credit check uses the registered count only, so a response handshake
    // in a full cycle cannot open a grant until the following cycle.
    assign w_credit_ok = (r_outstanding < cnt_w_lp'(max_outstanding_p));

    // Grants are also masked during reset so nothing leaks out while the
    // tracking state is being cleared.
    assign w_eligible  = cmd_v_i & {num_req_p{w_credit_ok & ~freeze_i & ~reset_i}};

    // Round-robin pick: first eligible index at or after r_rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        w_sel     = '0;
        w_grant_v = 1'b0;
        w_idx     = 0;
        for (int i = 0; i < num_req_p; i++) begin
            w_idx = (int'(r_rr_ptr) + i) % num_req_p;
            if (!w_grant_v && w_eligible[w_idx]) begin
                w_grant_v = 1'b1;
                w_sel     = lg_req_lp'(w_idx);
            end
        end
    end

    assign mem_cmd_v_o = w_grant_v;
    assign w_cmd_hs    = w_grant_v & mem_cmd_ready_i;

    always_comb begin
        mem_cmd_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (w_sel == lg_req_lp'(i)) begin
                mem_cmd_o = cmd_i[i*msg_width_p +: msg_width_p];
            end
        end
    end

    always_comb begin
        cmd_yumi_o = '0;
        if (w_cmd_hs) begin
            cmd_yumi_o[w_sel] = 1'b1;
        end
    end

    // Response routing: the order FIFO holds exactly r_outstanding entries,
    // so the count doubles as its occupancy.
    assign w_head    = r_order_mem[r_rd_ptr];
    assign w_resp_ok = mem_resp_v_i & (r_outstanding != '0);
    assign w_resp_hs = w_resp_ok & resp_yumi_i[w_head];

    always_comb begin
        resp_v_o = '0;
        if (w_resp_ok) begin
            resp_v_o[w_head] = 1'b1;
        end
    end

    assign resp_o          = mem_resp_i;
    assign mem_resp_yumi_o = w_resp_hs;

    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset_i) begin
            r_rr_ptr      <= '0;
            r_outstanding <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_error       <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_rr_ptr <= (w_sel == lg_req_lp'(num_req_p - 1)) ? '0 : w_sel + 1'b1;
                r_wr_ptr <= (r_wr_ptr == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_resp_hs) begin
                r_rd_ptr <= (r_rd_ptr == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_cmd_hs && !w_resp_hs) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (w_resp_hs && !w_cmd_hs) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
            // A response with nothing outstanding is a protocol error. It is
            // never consumed, because w_resp_ok is low.
            if (mem_resp_v_i && (r_outstanding == '0)) begin
                r_error <= 1'b1;
            end
        end
    end

    // NOTE: FIFO storage has no reset. Entries are only read behind a
    // non-zero count, and the pointers and count are reset.
    always_ff @(posedge clk_i) begin
        if (w_cmd_hs) begin
            r_order_mem[r_wr_ptr] <= w_sel;
        end
    end

    assign outstanding_o = r_outstanding;
    assign idle_o        = (r_outstanding == '0);
    assign error_o       = r_error;

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bp_me_mem_cmd_arbiter
//
// Directed scoreboard bench for bp_me_mem_cmd_arbiter (2 requesters,
// 16-bit messages, 4 credits).
//   - Stimulus pushes the expected grant or response into a queue.
//   - A negedge monitor pops the queue and compares on every command or
//     response handshake.
//   - State checks (count, idle, error, masking) run from the stimulus
//     process, 1 ns after the falling edge.
// ----------------------------------------------------------------------------
module tb_bp_me_mem_cmd_arbiter;

    localparam int NR = 2;
    localparam int MW = 16;
    localparam int MO = 4;
    localparam logic [MW-1:0] D0 = 16'hA0A0;
    localparam logic [MW-1:0] D1 = 16'hB1B1;

    typedef struct {
        logic [NR-1:0] yumi;
        logic [MW-1:0] data;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              freeze_i;
    logic [NR*MW-1:0]  cmd_i;
    logic [NR-1:0]     cmd_v_i;
    logic [NR-1:0]     cmd_yumi_o;
    logic [MW-1:0]     mem_cmd_o;
    logic              mem_cmd_v_o;
    logic              mem_cmd_ready_i;
    logic [MW-1:0]     mem_resp_i;
    logic              mem_resp_v_i;
    logic              mem_resp_yumi_o;
    logic [MW-1:0]     resp_o;
    logic [NR-1:0]     resp_v_o;
    logic [NR-1:0]     resp_yumi_i;
    logic [2:0]        outstanding_o;
    logic              idle_o;
    logic              error_o;

    int n_cmp = 0;
    int n_err = 0;
    exp_t cmd_q[$];
    exp_t resp_q[$];

    always #5 clk_i = ~clk_i;

    bp_me_mem_cmd_arbiter #(
        .num_req_p        (NR),
        .msg_width_p      (MW),
        .max_outstanding_p(MO)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .freeze_i       (freeze_i),
        .cmd_i          (cmd_i),
        .cmd_v_i        (cmd_v_i),
        .cmd_yumi_o     (cmd_yumi_o),
        .mem_cmd_o      (mem_cmd_o),
        .mem_cmd_v_o    (mem_cmd_v_o),
        .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_resp_i     (mem_resp_i),
        .mem_resp_v_i   (mem_resp_v_i),
        .mem_resp_yumi_o(mem_resp_yumi_o),
        .resp_o         (resp_o),
        .resp_v_o       (resp_v_o),
        .resp_yumi_i    (resp_yumi_i),
        .outstanding_o  (outstanding_o),
        .idle_o         (idle_o),
        .error_o        (error_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to n rising edges later, then 1 ns past the edge (drive point).
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Move to 1 ns after the next falling edge (sample point).
    task automatic at_neg();
        @(negedge clk_i);
        #1;
    endtask

    task automatic exp_cmd(input int sel);
        exp_t e;
        e.yumi = NR'(1) << sel;
        e.data = (sel == 1) ? D1 : D0;
        cmd_q.push_back(e);
    endtask

    task automatic exp_resp(input int head, input logic [MW-1:0] d);
        exp_t e;
        e.yumi = NR'(1) << head;
        e.data = d;
        resp_q.push_back(e);
    endtask

    // Monitor: every handshake must match the oldest expected entry.
    always @(negedge clk_i) begin
        exp_t e;
        if (mem_cmd_v_o && mem_cmd_ready_i) begin
            if (cmd_q.size() == 0) begin
                check("unexpected_grant", 32'(cmd_yumi_o), 32'h0);
            end else begin
                e = cmd_q.pop_front();
                check("grant_yumi", 32'(cmd_yumi_o), 32'(e.yumi));
                check("grant_data", 32'(mem_cmd_o), 32'(e.data));
            end
        end
        if (mem_resp_yumi_o) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 32'(resp_v_o), 32'h0);
            end else begin
                e = resp_q.pop_front();
                check("resp_v", 32'(resp_v_o), 32'(e.yumi));
                check("resp_data", 32'(resp_o), 32'(e.data));
            end
        end
    end

    initial begin
        reset_i         = 1'b1;
        freeze_i        = 1'b0;
        cmd_i           = {D1, D0};
        cmd_v_i         = 2'b11;
        mem_cmd_ready_i = 1'b1;
        mem_resp_i      = '0;
        mem_resp_v_i    = 1'b1;
        resp_yumi_i     = 2'b11;

        // Reset state, with active inputs that must be masked.
        tick(1);
        at_neg();
        check("rst_cmd_v", 32'(mem_cmd_v_o), 32'h0);
        check("rst_cmd_yumi", 32'(cmd_yumi_o), 32'h0);
        check("rst_resp_v", 32'(resp_v_o), 32'h0);
        check("rst_resp_yumi", 32'(mem_resp_yumi_o), 32'h0);
        check("rst_idle", 32'(idle_o), 32'h1);
        check("rst_out", 32'(outstanding_o), 32'h0);
        check("rst_err", 32'(error_o), 32'h0);

        // Round-robin: grants 0,1,0,1, then credits are exhausted.
        tick(1);
        reset_i      = 1'b0;
        mem_resp_v_i = 1'b0;
        exp_cmd(0); exp_cmd(1); exp_cmd(0); exp_cmd(1);
        tick(4);
        at_neg();
        check("rr_out_full", 32'(outstanding_o), 32'd4);
        check("rr_full_cmd_v", 32'(mem_cmd_v_o), 32'h0);
        check("rr_idle", 32'(idle_o), 32'h0);

        // Drain. The first response lands while full, so no same-cycle grant.
        tick(1);
        mem_resp_v_i = 1'b1;
        mem_resp_i   = 16'hC000; exp_resp(0, 16'hC000);
        at_neg();
        check("full_no_grant", 32'(mem_cmd_v_o), 32'h0);
        tick(1);
        cmd_v_i    = 2'b00;
        mem_resp_i = 16'hC001; exp_resp(1, 16'hC001);
        tick(1);
        mem_resp_i = 16'hC002; exp_resp(0, 16'hC002);
        tick(1);
        mem_resp_i = 16'hC003; exp_resp(1, 16'hC003);
        tick(1);
        mem_resp_v_i = 1'b0;
        at_neg();
        check("drain_idle", 32'(idle_o), 32'h1);
        check("drain_out", 32'(outstanding_o), 32'h0);

        // Routing: commands from requesters 1,0,1; responses go 10,01,10.
        tick(1);
        cmd_v_i = 2'b10; exp_cmd(1);
        tick(1);
        cmd_v_i = 2'b01; exp_cmd(0);
        tick(1);
        cmd_v_i = 2'b10; exp_cmd(1);
        tick(1);
        cmd_v_i      = 2'b00;
        mem_resp_v_i = 1'b1;
        mem_resp_i   = 16'hD001; exp_resp(1, 16'hD001);
        tick(1);
        mem_resp_i = 16'hD002; exp_resp(0, 16'hD002);
        tick(1);
        mem_resp_i = 16'hD003; exp_resp(1, 16'hD003);
        tick(1);
        mem_resp_v_i = 1'b0;
        at_neg();
        check("route_idle", 32'(idle_o), 32'h1);

        // Backpressure: head is requester 0; requester 1's yumi is ignored.
        tick(1);
        cmd_v_i = 2'b01; exp_cmd(0);
        tick(1);
        cmd_v_i      = 2'b00;
        mem_resp_v_i = 1'b1;
        mem_resp_i   = 16'hE0E0;
        resp_yumi_i  = 2'b10;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            check("bp_resp_v", 32'(resp_v_o), 32'h1);
            check("bp_yumi", 32'(mem_resp_yumi_o), 32'h0);
            check("bp_data", 32'(resp_o), 32'hE0E0);
            tick(1);
        end
        check("bp_out", 32'(outstanding_o), 32'd1);
        resp_yumi_i = 2'b01; exp_resp(0, 16'hE0E0);
        tick(1);
        mem_resp_v_i = 1'b0;
        resp_yumi_i  = 2'b11;
        at_neg();
        check("bp_idle", 32'(idle_o), 32'h1);

        // Simultaneous: count at 2, then command and response in one cycle.
        // Order FIFO goes [1,0] -> [0,1].
        tick(1);
        cmd_v_i = 2'b11; exp_cmd(1); exp_cmd(0);
        tick(2);
        mem_resp_v_i = 1'b1;
        mem_resp_i   = 16'hF001;
        exp_cmd(1);
        exp_resp(1, 16'hF001);
        at_neg();
        check("sim_out_pre", 32'(outstanding_o), 32'd2);
        tick(1);
        cmd_v_i    = 2'b00;
        mem_resp_i = 16'hF002; exp_resp(0, 16'hF002);
        at_neg();
        check("sim_out_post", 32'(outstanding_o), 32'd2);
        tick(1);
        mem_resp_i = 16'hF003; exp_resp(1, 16'hF003);
        tick(1);
        mem_resp_v_i = 1'b0;
        at_neg();
        check("sim_idle", 32'(idle_o), 32'h1);

        // Freeze: 2 outstanding, no new grants, both responses delivered.
        tick(1);
        cmd_v_i = 2'b11; exp_cmd(0); exp_cmd(1);
        tick(2);
        freeze_i = 1'b1;
        at_neg();
        check("frz_cmd_v", 32'(mem_cmd_v_o), 32'h0);
        check("frz_cmd_yumi", 32'(cmd_yumi_o), 32'h0);
        tick(1);
        mem_resp_v_i = 1'b1;
        mem_resp_i   = 16'h1111; exp_resp(0, 16'h1111);
        tick(1);
        mem_resp_i = 16'h2222; exp_resp(1, 16'h2222);
        tick(1);
        mem_resp_v_i = 1'b0;
        at_neg();
        check("frz_out", 32'(outstanding_o), 32'h0);
        check("frz_cmd_v_idle", 32'(mem_cmd_v_o), 32'h0);
        tick(1);
        freeze_i = 1'b0;
        cmd_v_i  = 2'b00;

        // Error: response with nothing outstanding, plus a same-cycle grant.
        tick(1);
        cmd_v_i      = 2'b10; exp_cmd(1);
        mem_resp_v_i = 1'b1;
        mem_resp_i   = 16'h5555;
        at_neg();
        check("err_resp_yumi", 32'(mem_resp_yumi_o), 32'h0);
        check("err_resp_v", 32'(resp_v_o), 32'h0);
        check("err_pre", 32'(error_o), 32'h0);
        tick(1);
        cmd_v_i      = 2'b00;
        mem_resp_v_i = 1'b0;
        at_neg();
        check("err_set", 32'(error_o), 32'h1);
        check("err_out", 32'(outstanding_o), 32'd1);
        tick(1);
        mem_resp_v_i = 1'b1;
        mem_resp_i   = 16'h6666; exp_resp(1, 16'h6666);
        tick(1);
        mem_resp_v_i = 1'b0;
        at_neg();
        check("err_sticky", 32'(error_o), 32'h1);
        check("err_idle", 32'(idle_o), 32'h1);

        // Reset with 3 outstanding (grants 0,1,0 leave the pointer at 1).
        tick(1);
        cmd_v_i = 2'b11; exp_cmd(0); exp_cmd(1); exp_cmd(0);
        tick(3);
        cmd_v_i = 2'b00;
        check("pre_rst_out", 32'(outstanding_o), 32'd3);
        #2;
        reset_i      = 1'b1;
        cmd_v_i      = 2'b11;
        mem_resp_v_i = 1'b1;
        #1;
        check("mid_rst_out", 32'(outstanding_o), 32'h0);
        check("mid_rst_idle", 32'(idle_o), 32'h1);
        check("mid_rst_cmd_v", 32'(mem_cmd_v_o), 32'h0);
        check("mid_rst_resp_v", 32'(resp_v_o), 32'h0);
        check("mid_rst_err", 32'(error_o), 32'h0);
        tick(1);
        // After reset the pointer is 0, so requester 0 wins with both valid.
        reset_i      = 1'b0;
        mem_resp_v_i = 1'b0;
        exp_cmd(0);
        tick(1);
        cmd_v_i      = 2'b00;
        mem_resp_v_i = 1'b1;
        mem_resp_i   = 16'h7777; exp_resp(0, 16'h7777);
        tick(1);
        mem_resp_v_i = 1'b0;
        at_neg();
        check("end_idle", 32'(idle_o), 32'h1);
        check("end_cmd_q_empty", 32'(cmd_q.size()), 32'h0);
        check("end_resp_q_empty", 32'(resp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
